// File: rtl/bcd_count_sequencer.sv
// bcd_count_sequencer: steps a 2-digit BCD counter toward a commanded target at a prescaled rate.
module bcd_count_sequencer #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic       hold,
  output logic [7:0] count,
  output logic       x,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] target, target_nx, count_nx, pre, pre_nx, stepped;
  logic x_nx, err_nx, bad, tick;
  assign bad = cmd_target[7:4] > 4'd9 || cmd_target[3:0] > 4'd9;
  assign tick = !hold && pre == 8'(PRESCALE - 1);
  assign stepped = x ? (count[3:0] == 4'd9 ? {count[7:4] + 4'd1, 4'd0} : {count[7:4], count[3:0] + 4'd1})
                     : (count[3:0] == 4'd0 ? {count[7:4] - 4'd1, 4'd9} : {count[7:4], count[3:0] - 4'd1});
  assign cmd_ready = state == IDLE;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    target_nx = target;
    count_nx = count;
    pre_nx = pre;
    x_nx = x;
    err_nx = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        if (bad) err_nx = 1'b1;
        else if (cmd_target == count) state_nx = DONE;
        else begin
          x_nx = cmd_target > count;
          target_nx = cmd_target;
          pre_nx = 8'd0;
          state_nx = RUN;
        end
      end
      RUN: if (!hold) begin
        pre_nx = tick ? 8'd0 : pre + 8'd1;
        if (tick) begin
          count_nx = stepped;
          state_nx = stepped == target ? DONE : RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      target <= 8'h00;
      count <= 8'h00;
      pre <= 8'd0;
      x <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      target <= target_nx;
      count <= count_nx;
      pre <= pre_nx;
      x <= x_nx;
      err <= err_nx;
    end
  end
endmodule
